// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback buffers.
// Define RFARB_RR_EN for round-robin arbitration; fixed priority A>B otherwise.
module regfile_write_arbiter #(
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 8,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_wa,
  input  logic [DW-1:0]   a_wd,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_wa,
  input  logic [DW-1:0]   b_wd,
  output logic            regwrite,
  output logic [AW-1:0]   wa,
  output logic [DW-1:0]   wd,
  output logic            idle,
  output logic [CNTW-1:0] drop_cnt
);

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } entry_t;

  logic            a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  entry_t          a_ent_q, a_ent_d, b_ent_q, b_ent_d;
  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
  logic            grant_a_c, grant_b_c;
  logic            a_acc_c, b_acc_c;
  entry_t          sel_c;

`ifdef RFARB_RR_EN
  // last_b_q set means B received the most recent grant.
  logic last_b_q, last_b_d;

  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (a_vld_q && b_vld_q) begin
      grant_a_c = last_b_q;
      grant_b_c = !last_b_q;
    end else begin
      grant_a_c = a_vld_q;
      grant_b_c = b_vld_q;
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    if (grant_a_c) begin
      last_b_d = 1'b0;
    end else if (grant_b_c) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  assign grant_a_c = a_vld_q;
  assign grant_b_c = b_vld_q && !a_vld_q;
`endif

  // Ready depends only on registered buffer state, never on an input valid.
  assign a_ready = !a_vld_q || grant_a_c;
  assign b_ready = !b_vld_q || grant_b_c;
  assign a_acc_c = a_valid && a_ready;
  assign b_acc_c = b_valid && b_ready;

  always_comb begin
    a_vld_d = a_vld_q;
    a_ent_d = a_ent_q;
    b_vld_d = b_vld_q;
    b_ent_d = b_ent_q;
    if (grant_a_c) a_vld_d = 1'b0;
    if (grant_b_c) b_vld_d = 1'b0;
    if (a_acc_c) begin
      a_vld_d = 1'b1;
      a_ent_d = '{wa: a_wa, wd: a_wd};
    end
    if (b_acc_c) begin
      b_vld_d = 1'b1;
      b_ent_d = '{wa: b_wa, wd: b_wd};
    end
  end

  // Output stage: writes to r0 are consumed but suppressed and counted.
  always_comb begin
    regwrite_d = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    drop_cnt_d = drop_cnt_q;
    sel_c      = grant_a_c ? a_ent_q : b_ent_q;
    if (grant_a_c || grant_b_c) begin
      if (sel_c.wa != '0) begin
        regwrite_d = 1'b1;
        wa_d       = sel_c.wa;
        wd_d       = sel_c.wd;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q    <= 1'b0;
      a_ent_q    <= '0;
      b_vld_q    <= 1'b0;
      b_ent_q    <= '0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      drop_cnt_q <= '0;
    end else begin
      a_vld_q    <= a_vld_d;
      a_ent_q    <= a_ent_d;
      b_vld_q    <= b_vld_d;
      b_ent_q    <= b_ent_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign regwrite = regwrite_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign drop_cnt = drop_cnt_q;
  assign idle     = !a_vld_q && !b_vld_q && !regwrite_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (default fixed-priority build).
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [4:0] a_wa, b_wa, wa;
  logic [7:0] a_wd, b_wd, wd, drop_cnt;
  logic       regwrite, idle;

  typedef struct {
    logic [4:0] wa;
    logic [7:0] wd;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rf[32];
  int         edge_n = 0;
  int         total = 0;
  int         bad = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_wa(a_wa), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
    .regwrite(regwrite), .wa(wa), .wd(wd), .idle(idle), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  // Stand-in for register_file: r0 is hardwired to zero.
  always @(posedge clk) if (regwrite === 1'b1 && wa != 5'd0) rf[wa] <= wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] ea, input logic [7:0] ed, input int ec);
    exp_t e;
    e.wa = ea;
    e.wd = ed;
    e.cyc = ec;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check(tag, 32'(sb.size()), 32'd0);
    tick();
    tick();
  endtask

  // Every regwrite pulse must match the next expected write, in the expected cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && regwrite === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_regwrite", {27'd0, wa}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_wa", 32'(wa), 32'(e.wa));
        check("wr_wd", 32'(wd), 32'(e.wd));
        check("wr_cycle", 32'(edge_n), 32'(e.cyc));
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 8'h00;
    rst_n = 1'b0;
    a_valid = 1'b0; a_wa = '0; a_wd = '0;
    b_valid = 1'b0; b_wa = '0; b_wd = '0;
    #1;
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ready", {30'd0, a_ready, b_ready}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single write from A
    a_valid = 1'b1; a_wa = 5'd1; a_wd = 8'hAA;
    tick();
    expect_wr(5'd1, 8'hAA, edge_n + 1);
    a_valid = 1'b0;
    drain("single_drain");
    check("single_rf1", 32'(rf[1]), 32'hAA);
    check("single_idle", 32'(idle), 32'd1);

    // Contention: A wins, B follows next cycle
    a_valid = 1'b1; a_wa = 5'd2; a_wd = 8'h55;
    b_valid = 1'b1; b_wa = 5'd3; b_wd = 8'h33;
    tick();
    expect_wr(5'd2, 8'h55, edge_n + 1);
    expect_wr(5'd3, 8'h33, edge_n + 2);
    a_valid = 1'b0; b_valid = 1'b0;
    check("cont_b_ready_wait", 32'(b_ready), 32'd0);
    check("cont_idle_busy", 32'(idle), 32'd0);
    tick();
    check("cont_b_ready_grant", 32'(b_ready), 32'd1);
    drain("cont_drain");
    check("cont_rf2", 32'(rf[2]), 32'h55);
    check("cont_rf3", 32'(rf[3]), 32'h33);

    // r0 drop
    b_valid = 1'b1; b_wa = 5'd0; b_wd = 8'hFF;
    tick();
    b_valid = 1'b0;
    tick(); tick();
    check("drop_cnt_one", 32'(drop_cnt), 32'd1);
    check("drop_rf0", 32'(rf[0]), 32'h00);
    check("drop_idle", 32'(idle), 32'd1);

    // Same-address ordering
    a_valid = 1'b1; a_wa = 5'd4; a_wd = 8'h11;
    b_valid = 1'b1; b_wa = 5'd4; b_wd = 8'h22;
    tick();
    expect_wr(5'd4, 8'h11, edge_n + 1);
    expect_wr(5'd4, 8'h22, edge_n + 2);
    a_valid = 1'b0; b_valid = 1'b0;
    drain("same_drain");
    check("same_rf4", 32'(rf[4]), 32'h22);

    // Streaming from A, one transfer per cycle
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_wa = 5'(8 + i); a_wd = 8'(8'hA0 + i);
      check("stream_a_ready", 32'(a_ready), 32'd1);
      tick();
      expect_wr(5'(8 + i), 8'(8'hA0 + i), edge_n + 1);
    end
    a_valid = 1'b0;
    drain("stream_drain");
    check("stream_rf15", 32'(rf[15]), 32'hA7);
    check("stream_idle", 32'(idle), 32'd1);

    // Drop counter saturation
    b_valid = 1'b1; b_wa = 5'd0; b_wd = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) check("sat_b_ready", 32'(b_ready), 32'd1);
      tick();
    end
    b_valid = 1'b0;
    tick(); tick();
    check("sat_drop_cnt", 32'(drop_cnt), 32'hFF);

    // Reset mid-operation with both buffers full and a write in flight
    a_valid = 1'b1; a_wa = 5'd5; a_wd = 8'h77;
    b_valid = 1'b1; b_wa = 5'd6; b_wd = 8'h66;
    tick();
    expect_wr(5'd5, 8'h77, edge_n + 1);
    a_wa = 5'd7; a_wd = 8'h44; b_valid = 1'b0;
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_b_ready", 32'(b_ready), 32'd0);
    check("pre_rst_regwrite", 32'(regwrite), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_regwrite", 32'(regwrite), 32'd0);
    check("mid_rst_wa_wd", {19'd0, wa, wd}, 32'd0);
    check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {30'd0, a_ready, b_ready}, 32'd3);
    check("post_rst_idle", 32'(idle), 32'd1);
    tick(); tick(); tick();
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);
    check("post_rst_rf6", 32'(rf[6]), 32'h00);
    check("post_rst_rf7", 32'(rf[7]), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (regwrite/wa/wd, 5-bit address, 8-bit data) between two writeback requesters.
- Requester A is the ALU writeback; requester B is the load/memory writeback.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- The arbiter drains the buffers onto registered write-port outputs that connect directly to register_file.

Parameters:
- AW, 5, register address width.
- DW, 8, register data width.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A write request.
- a_ready  output  1  requester A buffer can accept.
- a_wa  input  AW  requester A destination register.
- a_wd  input  DW  requester A write data.
- b_valid  input  1  requester B write request.
- b_ready  output  1  requester B buffer can accept.
- b_wa  input  AW  requester B destination register.
- b_wd  input  DW  requester B write data.
- regwrite  output  1  write enable to register_file, registered.
- wa  output  AW  write address to register_file, registered.
- wd  output  DW  write data to register_file, registered.
- idle  output  1  both buffers empty and regwrite low.
- drop_cnt  output  CNTW  saturating count of requests that targeted r0.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset rst_n is asynchronous, active-low.
- Reset values:
  - regwrite=0, wa=0, wd=0, drop_cnt=0.
  - Both buffers empty, so a_ready=b_ready=1 and idle=1.
  - Arbitration pointer points at B, so A wins first.
- Handshake:
  - A transfer occurs on a rising edge where x_valid && x_ready; x_wa/x_wd are captured into buffer x.
  - x_ready = !buf_x_valid || grant_x.
  - grant_x depends only on registered buffer state. There is no combinational path from any input valid to any ready.
- Arbitration, each cycle:
  - Candidates are the buffers with valid entries.
  - At most one grant per cycle.
  - A granted buffer is cleared at the edge unless it is refilled at the same edge. Simultaneous drain and refill of the same buffer is legal and keeps 1 transfer/cycle per requester when uncontested.
- Output stage, at each edge:
  - If granted and the entry's wa != 0: regwrite<=1, wa<=entry wa, wd<=entry wd.
  - If granted and the entry's wa == 0: regwrite<=0, wa/wd hold, drop_cnt increments (saturates at all-ones). The entry is still consumed.
  - If no grant: regwrite<=0, wa/wd hold.
- Latency:
  - Accept at edge N, grant evaluated in cycle N→N+1, regwrite high during cycle N+1→N+2, register_file writes at edge N+2.
  - Minimum input-to-regfile latency is 2 edges.
  - A losing request waits one extra cycle per lost arbitration.
- Ordering:
  - Per-requester order is preserved (single buffer).
  - If A and B target the same register, grant order decides: the later grant's data is final.
- Fairness:
  - Default is fixed priority, A over B.
  - B can starve only if A presents a new request every cycle. This is permitted without the optional feature.
- Reset mid-operation: buffered entries and an in-flight output write are discarded, and outputs return to their reset values immediately (asynchronous).
- idle = !buf_a_valid && !buf_b_valid && !regwrite.

Optional Feature:
- Macro: RFARB_RR_EN.
- Defined:
  - Round-robin arbitration using a 1-bit last-grant register, updated on every grant.
  - When both buffers are valid, the requester not granted last wins.
  - Reset value of last-grant is B, so A wins the first tie.
  - No requester waits more than one grant.
- Undefined:
  - Fixed priority A>B.
  - The last-grant register is not instantiated.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with both buffers full -> outputs and drop_cnt 0 immediately; after release a_ready=b_ready=1 and idle=1.
- Single write: A sends wa=1, wd=0xAA at edge N -> regwrite=1, wa=1, wd=0xAA during N+1; register_file rd of r1 = 0xAA after edge N+2; idle returns 1.
- Contention: A (wa=2, wd=0x55) and B (wa=3, wd=0x33) both valid at the same edge.
  - -> A is written first, B the next cycle.
  - b_ready stays 0 until B is granted.
- r0 drop: B sends wa=0, wd=0xFF -> regwrite stays 0, drop_cnt increments 0→1, and r0 still reads 0x00.
  - Sending 300 such requests -> drop_cnt saturates at 0xFF.
- Same-address ordering: A writes r4=0x11 and B writes r4=0x22 at the same edge -> final r4 = 0x22 (fixed priority).
- Streaming: A valid every cycle for 8 cycles with B idle -> a_ready stays 1 and 8 consecutive regwrite pulses occur.
  - With RFARB_RR_EN and B also valid every cycle -> grants alternate A, B, A, B, and neither requester waits more than one cycle.
